output_port_scheduler: RTL and testbench

Per-output-port scheduler for the 8-bit router datapath. It arbitrates round-robin among N_IN input packet buffers that each hold a complete packet for this output port. It then streams the granted packet, one byte per transfer, to the port's receiver over the `ready`/`read` handshake. It sits between the input buffer array and each router output port, one instance per port.

---
 rtl/output_port_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_output_port_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_scheduler.sv
// -----------------------------------------------------------------------------
// output_port_scheduler
//
// Per-output-port scheduler for the 8-bit router datapath. It arbitrates
// round-robin among N_IN input buffers that each hold a complete packet for
// this port. It then streams the granted packet to the port's receiver, one
// byte per ready/read handshake.
//
// Ports:
//   clk          single clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   in_req       input i holds at least one complete packet
//   in_data      head byte of input i (bits 8i+7:8i)
//   in_last      head byte of input i is the last byte of its packet
//   in_pop       one-hot, advances the head of the granted input on a transfer
//   ready        a packet is being offered/streamed to the receiver
//   read         receiver accepts the byte on this edge
//   data         byte to receiver (8'h00 while ready is low)
//   port         constant PORT_ID
//   src          index of the granted input
//   busy         scheduler is not idle
//   timeout_err  one-cycle pulse when an offer is abandoned
// -----------------------------------------------------------------------------
module output_port_scheduler #(
   parameter int N_IN       = 4,
   parameter int PORT_ID    = 0,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 64
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [N_IN-1:0]         in_req,
   input  logic [8*N_IN-1:0]       in_data,
   input  logic [N_IN-1:0]         in_last,
   output logic [N_IN-1:0]         in_pop,
   output logic                    ready,
   input  logic                    read,
   output logic [7:0]              data,
   output logic [7:0]              port,
   output logic [$clog2(N_IN)-1:0] src,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int SW = $clog2(N_IN);
   localparam int TW = $clog2(TIMEOUT);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      XFER  = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t          state_r;
   logic [SW-1:0]   src_r;
   logic [SW-1:0]   last_grant_r;
   logic [GW-1:0]   gap_cnt_r;
   logic [TW-1:0]   to_cnt_r;
   logic            ready_r;
   logic            busy_r;
   logic            terr_r;

   logic            grant_valid_s;
   logic [SW-1:0]   grant_idx_s;
   logic [SW-1:0]   cand_s;
   logic            xfer_s;
   logic            head_last_s;
   logic [7:0]      head_data_s;
   logic [N_IN-1:0] in_pop_s;

   // Round-robin search: first requester after last_grant, wrapping around.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_idx_s   = {SW{1'b0}};
      cand_s        = {SW{1'b0}};
      for (int k = 1; k <= N_IN; k++) begin
         cand_s = SW'((int'(last_grant_r) + k) % N_IN);
         if (!grant_valid_s && in_req[cand_s]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = cand_s;
         end else begin
            grant_valid_s = grant_valid_s;
         end
      end
   end

   // Head-of-line view of the granted input and the transfer strobe.
   always_comb begin
      xfer_s      = ready_r & read;
      head_last_s = in_last[src_r];
      head_data_s = in_data[{src_r, 3'b000} +: 8];
      in_pop_s    = {N_IN{1'b0}};
      if (xfer_s) begin
         in_pop_s[src_r] = 1'b1;
      end else begin
         in_pop_s = {N_IN{1'b0}};
      end
   end

   // Scheduler FSM; ready/busy are registered alongside the state so they
   // never glitch, and clear immediately on the asynchronous reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         src_r        <= {SW{1'b0}};
         last_grant_r <= SW'(N_IN - 1);
         gap_cnt_r    <= {GW{1'b0}};
         to_cnt_r     <= {TW{1'b0}};
         ready_r      <= 1'b0;
         busy_r       <= 1'b0;
         terr_r       <= 1'b0;
      end else begin
         terr_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_valid_s) begin
                  src_r    <= grant_idx_s;
                  to_cnt_r <= {TW{1'b0}};
                  state_r  <= OFFER;
                  ready_r  <= 1'b1;
                  busy_r   <= 1'b1;
               end else begin
                  ready_r <= 1'b0;
                  busy_r  <= 1'b0;
               end
            end
            OFFER: begin
               if (read) begin
                  if (head_last_s) begin
                     // Single-byte packet: done on the first transfer.
                     last_grant_r <= src_r;
                     gap_cnt_r    <= GW'(GAP_CYCLES - 1);
                     state_r      <= GAP;
                     ready_r      <= 1'b0;
                  end else begin
                     state_r <= XFER;
                  end
               end else if (to_cnt_r == TW'(TIMEOUT - 1)) begin
                  // Abandon the offer; no byte is popped from the input.
                  terr_r       <= 1'b1;
                  last_grant_r <= src_r;
                  gap_cnt_r    <= GW'(GAP_CYCLES - 1);
                  state_r      <= GAP;
                  ready_r      <= 1'b0;
               end else begin
                  to_cnt_r <= to_cnt_r + TW'(1);
               end
            end
            XFER: begin
               if (read && head_last_s) begin
                  last_grant_r <= src_r;
                  gap_cnt_r    <= GW'(GAP_CYCLES - 1);
                  state_r      <= GAP;
                  ready_r      <= 1'b0;
               end else begin
                  // Either streaming a middle byte or stalled holding it.
                  state_r <= XFER;
               end
            end
            GAP: begin
               if (gap_cnt_r == {GW{1'b0}}) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  gap_cnt_r <= gap_cnt_r - GW'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               ready_r <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Output drive: data and in_pop follow src/read combinationally.
   always_comb begin
      if (ready_r) begin
         data = head_data_s;
      end else begin
         data = 8'h00;
      end
   end

   assign in_pop      = in_pop_s;
   assign ready       = ready_r;
   assign busy        = busy_r;
   assign src         = src_r;
   assign timeout_err = terr_r;
   assign port        = 8'(PORT_ID);

endmodule

// File: tb/tb_output_port_scheduler.sv
module tb_output_port_scheduler;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [N-1:0]   in_req;
   logic [8*N-1:0] in_data;
   logic [N-1:0]   in_last;
   logic [N-1:0]   in_pop;
   logic           ready;
   logic           read = 1'b0;
   logic [7:0]     data;
   logic [7:0]     port;
   logic [1:0]     src;
   logic           busy;
   logic           timeout_err;

   output_port_scheduler #(
      .N_IN(4), .PORT_ID(5), .GAP_CYCLES(2), .TIMEOUT(64)
   ) dut (
      .clk(clk), .reset_n(reset_n), .in_req(in_req), .in_data(in_data),
      .in_last(in_last), .in_pop(in_pop), .ready(ready), .read(read),
      .data(data), .port(port), .src(src), .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Input buffer model: per-input byte store, popped by in_pop.
   int         pop_cnt [N] = '{default: 0};
   int         len     [N] = '{default: 0};
   logic [7:0] mem     [N][64];
   logic       lastf   [N][64];

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (in_pop[i]) pop_cnt[i] <= pop_cnt[i] + 1;
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         if (pop_cnt[i] < len[i]) begin
            in_req[i]         = 1'b1;
            in_data[8*i +: 8] = mem[i][pop_cnt[i][5:0]];
            in_last[i]        = lastf[i][pop_cnt[i][5:0]];
         end else begin
            in_req[i]         = 1'b0;
            in_data[8*i +: 8] = 8'h00;
            in_last[i]        = 1'b0;
         end
      end
   end

   int total = 0;
   int passed = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic push(input int i, input logic [7:0] b, input logic l);
      mem[i][len[i][5:0]]   = b;
      lastf[i][len[i][5:0]] = l;
      len[i] = len[i] + 1;
   endtask

   // Enter reset and empty all input buffers.
   task automatic start_scn();
      @(negedge clk);
      reset_n = 1'b0;
      read    = 1'b0;
      for (int i = 0; i < N; i++) len[i] = pop_cnt[i];
   endtask

   task automatic release_rst();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic       rd;
      logic       rdy;
      logic [7:0] dat;
      logic [3:0] pop;
      logic [1:0] s;
      logic       bsy;
      logic       terr;
   } row_t;

   row_t rows [16];

   function automatic row_t mk(logic rd, logic rdy, logic [7:0] d, logic [3:0] p,
                               logic [1:0] s, logic b, logic t);
      row_t r;
      r.rd = rd; r.rdy = rdy; r.dat = d; r.pop = p; r.s = s; r.bsy = b; r.terr = t;
      return r;
   endfunction

   task automatic run_rows(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         read = rows[k].rd;
         #1;
         chk($sformatf("%s[%0d].ready", tag, k), int'(ready), int'(rows[k].rdy));
         chk($sformatf("%s[%0d].data", tag, k), int'(data), int'(rows[k].dat));
         chk($sformatf("%s[%0d].in_pop", tag, k), int'(in_pop), int'(rows[k].pop));
         chk($sformatf("%s[%0d].src", tag, k), int'(src), int'(rows[k].s));
         chk($sformatf("%s[%0d].busy", tag, k), int'(busy), int'(rows[k].bsy));
         chk($sformatf("%s[%0d].terr", tag, k), int'(timeout_err), int'(rows[k].terr));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int low, pops, terrs, p1;

      // ---------------- reset + fairness ----------------
      for (int i = 0; i < N; i++) begin
         for (int n = 0; n < 2; n++) push(i, 8'(16*i + n + 1), 1'b1);
      end
      repeat (2) @(negedge clk);
      #1;
      chk("rst.ready", int'(ready), 0);
      chk("rst.data", int'(data), 0);
      chk("rst.in_pop", int'(in_pop), 0);
      chk("rst.busy", int'(busy), 0);
      chk("rst.src", int'(src), 0);
      chk("rst.terr", int'(timeout_err), 0);
      chk("port", int'(port), 5);
      reset_n = 1'b1;
      read    = 1'b1;
      for (int g = 0; g < 8; g++) begin
         @(negedge clk);
         #1;
         chk($sformatf("fair[%0d].ready", g), int'(ready), 1);
         chk($sformatf("fair[%0d].src", g), int'(src), g % 4);
         chk($sformatf("fair[%0d].data", g), int'(data), 16*(g % 4) + g/4 + 1);
         chk($sformatf("fair[%0d].in_pop", g), int'(in_pop), 1 << (g % 4));
         for (int z = 0; z < 3; z++) begin
            @(negedge clk);
            #1;
            chk($sformatf("fair[%0d].gap%0d", g, z), int'(ready), 0);
         end
      end

      // ---------------- single 3-byte packet on input 2 ----------------
      start_scn();
      push(2, 8'hA5, 1'b0); push(2, 8'h03, 1'b0); push(2, 8'h5A, 1'b1);
      release_rst();
      rows[0] = mk(1'b0, 1'b1, 8'hA5, 4'b0000, 2'd2, 1'b1, 1'b0);
      rows[1] = mk(1'b0, 1'b1, 8'hA5, 4'b0000, 2'd2, 1'b1, 1'b0);
      rows[2] = mk(1'b0, 1'b1, 8'hA5, 4'b0000, 2'd2, 1'b1, 1'b0);
      rows[3] = mk(1'b1, 1'b1, 8'hA5, 4'b0100, 2'd2, 1'b1, 1'b0);
      rows[4] = mk(1'b1, 1'b1, 8'h03, 4'b0100, 2'd2, 1'b1, 1'b0);
      rows[5] = mk(1'b1, 1'b1, 8'h5A, 4'b0100, 2'd2, 1'b1, 1'b0);
      rows[6] = mk(1'b1, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b1, 1'b0);
      rows[7] = mk(1'b1, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b1, 1'b0);
      rows[8] = mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b0, 1'b0);
      rows[9] = mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b0, 1'b0);
      run_rows(10, "single");

      // ---------------- stall mid-packet on input 1 ----------------
      start_scn();
      push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h33, 1'b0); push(1, 8'h44, 1'b1);
      release_rst();
      rows[0] = mk(1'b1, 1'b1, 8'h11, 4'b0010, 2'd1, 1'b1, 1'b0);
      rows[1] = mk(1'b1, 1'b1, 8'h22, 4'b0010, 2'd1, 1'b1, 1'b0);
      rows[2] = mk(1'b0, 1'b1, 8'h33, 4'b0000, 2'd1, 1'b1, 1'b0);
      rows[3] = mk(1'b0, 1'b1, 8'h33, 4'b0000, 2'd1, 1'b1, 1'b0);
      rows[4] = mk(1'b0, 1'b1, 8'h33, 4'b0000, 2'd1, 1'b1, 1'b0);
      rows[5] = mk(1'b0, 1'b1, 8'h33, 4'b0000, 2'd1, 1'b1, 1'b0);
      rows[6] = mk(1'b1, 1'b1, 8'h33, 4'b0010, 2'd1, 1'b1, 1'b0);
      rows[7] = mk(1'b1, 1'b1, 8'h44, 4'b0010, 2'd1, 1'b1, 1'b0);
      rows[8] = mk(1'b0, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b1, 1'b0);
      run_rows(9, "stall");

      // ---------------- offer timeout on input 1 ----------------
      start_scn();
      push(1, 8'h77, 1'b1);
      push(2, 8'h88, 1'b1);
      release_rst();
      p1 = pop_cnt[1];
      low = 0; pops = 0; terrs = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         #1;
         if (!ready) low++;
         if (in_pop != 4'b0000) pops++;
         if (timeout_err) terrs++;
         if (k == 0) chk("tmo.src", int'(src), 1);
      end
      chk("tmo.ready_low_early", low, 0);
      chk("tmo.pops_during_offer", pops, 0);
      chk("tmo.terr_early", terrs, 0);
      @(negedge clk);
      #1;
      chk("tmo.ready_fall", int'(ready), 0);
      chk("tmo.terr_pulse", int'(timeout_err), 1);
      chk("tmo.busy_gap", int'(busy), 1);
      @(negedge clk);
      #1;
      chk("tmo.terr_clear", int'(timeout_err), 0);
      chk("tmo.gap2_ready", int'(ready), 0);
      @(negedge clk);
      #1;
      chk("tmo.idle_ready", int'(ready), 0);
      @(negedge clk);
      read = 1'b1;
      #1;
      chk("tmo.next_ready", int'(ready), 1);
      chk("tmo.next_src", int'(src), 2);
      chk("tmo.next_data", int'(data), 8'h88);
      chk("tmo.input1_not_popped", pop_cnt[1], p1);

      // ---------------- reset during a multi-byte transfer ----------------
      start_scn();
      push(0, 8'hA1, 1'b0); push(0, 8'hB2, 1'b0); push(0, 8'hC3, 1'b1);
      push(1, 8'h21, 1'b1); push(2, 8'h31, 1'b1); push(3, 8'h41, 1'b1);
      release_rst();
      @(negedge clk);
      read = 1'b1;
      #1;
      chk("rmid.src", int'(src), 0);
      chk("rmid.byte1", int'(data), 8'hA1);
      @(negedge clk);
      #1;
      chk("rmid.byte2", int'(data), 8'hB2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rmid.ready", int'(ready), 0);
      chk("rmid.data", int'(data), 0);
      chk("rmid.in_pop", int'(in_pop), 0);
      chk("rmid.busy", int'(busy), 0);
      release_rst();
      @(negedge clk);
      #1;
      chk("rmid.regrant_ready", int'(ready), 1);
      chk("rmid.regrant_src", int'(src), 0);
      chk("rmid.regrant_data", int'(data), 8'hB2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
